id_ctrl_stage: RTL and testbench
================================

Name: id_ctrl_stage

Overview:
- Next-generation main decoder for the 5-stage MIPS pipeline.
- Decodes the full 32-bit instruction in ID, including the destination-register select, and registers all control fields into the ID/EX pipeline register.
- Detects load-use hazards and inserts bubbles; honours flushes from branch/jump resolution.
- Extends the single-cycle opcode set with bne, andi, ori, lui, j, jal and illegal-opcode reporting.

Parameters:
- ALUOP_W, 3: ALU op field width. Must be ≥3; bits above [2:0] are driven 0.
- REG_AW, 5: register address width.
- CNT_W, 16: width of the saturating stall and illegal counters.
- LOAD_USE_EN, 1: 1 enables hazard detection; 0 forces stall_o=0.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- instr_i  in  32  instruction in the IF/ID register
- instr_valid_i  in  1  instr_i holds a real instruction
- flush_i  in  1  discard the ID instruction (taken branch or jump redirect)
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid_o  out  1  ID/EX holds a real instruction
- ex_reg_write_o  out  1  ID/EX register-write enable
- ex_wreg_o  out  REG_AW  selected destination register
- ex_rs_o, ex_rt_o  out  REG_AW each  source register numbers, for forwarding
- ex_alu_op_o  out  ALUOP_W  ALU op class
- ex_alu_src_o  out  1  ALU operand B is the immediate
- ex_reg_dst_o  out  1  destination is rd
- ex_branch_o  out  1  beq or bne
- ex_branch_ne_o  out  1  bne
- ex_jump_o  out  1  j or jal
- ex_link_o  out  1  jal
- ex_mem_read_o  out  1  load
- ex_mem_write_o  out  1  store
- ex_mem_to_reg_o  out  1  write-back selects memory data
- illegal_o  out  1  one-cycle pulse, registered with ID/EX
- stall_cnt_o  out  CNT_W  saturating count of stall cycles
- illegal_cnt_o  out  CNT_W  saturating count of illegal opcodes

Behaviour:
- Reset: all ID/EX outputs, illegal_o and both counters go to 0 asynchronously. Reset mid-operation drops the in-flight instruction.
- Decode table (op → RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, ALUop):
  - 0x00 R-type → 1,0,0,1,0,0,010
  - 0x23 lw → 0,1,1,1,1,0,000
  - 0x2B sw → 0,1,0,0,0,1,000
  - 0x04 beq and 0x05 bne → 0,0,0,0,0,0,001, branch=1; bne also sets branch_ne=1
  - 0x08 addi → ALUop 011
  - 0x0A slti → ALUop 100
  - 0x0C andi → ALUop 101
  - 0x0D ori → ALUop 110
  - 0x0F lui → ALUop 111
  - addi, slti, andi, ori and lui all use 0,1,0,1,0,0
  - 0x02 j → jump=1, everything else 0
  - 0x03 jal → jump=1, link=1, RegWrite=1, wreg=31
  - any other opcode is illegal: all controls 0 (bubble) and illegal_o=1 for the cycle the instruction sits in EX.
- Destination: wreg=rd[15:11] if RegDst, 31 if link, otherwise rt[20:16].
- $0 writes: if wreg==0, reg_write is forced to 0.
- rt usage: rt counts as a source for R-type, sw, beq and bne. For all other opcodes it does not count.
- Hazard condition, evaluated combinationally:
  - hazard = LOAD_USE_EN & ex_valid_o & ex_mem_read_o & (ex_wreg_o≠0) & instr_valid_i, and
  - (ex_wreg_o==rs, or rt is used and ex_wreg_o==rt).
- stall_o = hazard & ~flush_i.
- Register update priority at each clock edge: reset > flush > stall > load.
  - Flush or stall: load a bubble (ex_valid_o=0, all controls 0, illegal_o=0).
  - !instr_valid_i: load a bubble.
  - Otherwise: load the decoded fields, ex_valid_o=1.
- Latency: exactly one cycle from ID to the ex_* outputs.
- A load-use stall lasts exactly one cycle. The bubble clears ex_mem_read_o, so the hazard self-releases.
- Counters: stall_cnt_o increments on each cycle with stall_o=1; illegal_cnt_o increments on each accepted illegal opcode. Both saturate at all-ones and do not wrap.
- Flush and hazard in the same cycle: flush wins; stall_o=0 and the stall counter does not increment.

Decomposition:
- Package mips_ctrl_pkg:
  - opcode localparams (OP_RTYPE, OP_LW, …)
  - ALU-op localparams (ALUOP_ADD=000 through ALUOP_LUI=111)
  - a packed ctrl_t struct holding all control bits, plus CTRL_BUBBLE.
- One natural sub-module: id_main_dec, the purely combinational op→ctrl_t table.
- Hazard logic, ID/EX register and counters stay in the top module.

Test Plan:
- Reset check: assert rst_i mid-stream with lw in ID → all ex_* outputs and both counters are 0 immediately, before any clock edge.
- Load-use: lw $8,0($1) then add $9,$8,$2 → stall_o=1 for one cycle, one bubble in EX, add reaches EX on the next cycle, stall_cnt_o=1.
- Store rt dependency: lw $8 then sw $8,4($3) → stall; lw $8 then addi $9,$8,1 → stall via rs. lw $0 then add $9,$0,$2 → no stall.
- Flush vs hazard: flush_i=1 in the same cycle as a hazard → stall_o=0, bubble loaded, stall_cnt_o unchanged.
- Decode coverage: each legal opcode in turn → table values. jal gives ex_wreg_o=31, reg_write=1. addi $0,$1,5 gives reg_write=0.
- Illegal opcode: op 0x3F → one bubble, illegal_o pulses one cycle, illegal_cnt_o=1. With CNT_W=2, five illegal opcodes → illegal_cnt_o saturates at 3.

Source files
------------

// File: rtl/id_ctrl_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : mips_ctrl_pkg                                              |
// | Description : Shared decode definitions for the ID control stage:        |
// |               opcode and ALU-op encodings, and the packed control word   |
// |               produced by the main decoder.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mips_ctrl_pkg;

   // Primary opcodes, instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // ALU op classes handed to the EX-stage ALU controller
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_FUNCT = 3'b010;
   localparam logic [2:0] ALUOP_ADDI  = 3'b011;
   localparam logic [2:0] ALUOP_SLT   = 3'b100;
   localparam logic [2:0] ALUOP_AND   = 3'b101;
   localparam logic [2:0] ALUOP_OR    = 3'b110;
   localparam logic [2:0] ALUOP_LUI   = 3'b111;

   typedef struct packed {
      logic       regDst;
      logic       aluSrc;
      logic       memToReg;
      logic       regWrite;
      logic       memRead;
      logic       memWrite;
      logic       branch;
      logic       branchNe;
      logic       jump;
      logic       link;
      logic       rtUsed;    // rt is a source operand (hazard check only)
      logic       illegal;
      logic [2:0] aluOp;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/id_ctrl_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : id_ctrl_stage_if                                           |
// | Description : Bundle between the IF/ID register / hazard unit and the    |
// |               ID control stage.                                          |
// |   master : drives instr_i, instr_valid_i, flush_i; receives the rest     |
// |   slave  : the ID control stage (id_ctrl_stage)                          |
// |   stall_o            hold PC and IF/ID (combinational)                   |
// |   ex_*               ID/EX pipeline register contents                     |
// |   illegal_o          one-cycle pulse with the illegal op in EX            |
// |   stall_cnt_o / illegal_cnt_o   saturating event counters              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface id_ctrl_stage_if #(
   parameter int ALUOP_W = 3,
   parameter int REG_AW  = 5,
   parameter int CNT_W   = 16
);
   logic [31:0]        instr_i;
   logic               instr_valid_i;
   logic               flush_i;
   logic               stall_o;
   logic               ex_valid_o;
   logic               ex_reg_write_o;
   logic [REG_AW-1:0]  ex_wreg_o;
   logic [REG_AW-1:0]  ex_rs_o;
   logic [REG_AW-1:0]  ex_rt_o;
   logic [ALUOP_W-1:0] ex_alu_op_o;
   logic               ex_alu_src_o;
   logic               ex_reg_dst_o;
   logic               ex_branch_o;
   logic               ex_branch_ne_o;
   logic               ex_jump_o;
   logic               ex_link_o;
   logic               ex_mem_read_o;
   logic               ex_mem_write_o;
   logic               ex_mem_to_reg_o;
   logic               illegal_o;
   logic [CNT_W-1:0]   stall_cnt_o;
   logic [CNT_W-1:0]   illegal_cnt_o;

   modport master (
      output instr_i, instr_valid_i, flush_i,
      input  stall_o, ex_valid_o, ex_reg_write_o, ex_wreg_o, ex_rs_o, ex_rt_o,
             ex_alu_op_o, ex_alu_src_o, ex_reg_dst_o, ex_branch_o,
             ex_branch_ne_o, ex_jump_o, ex_link_o, ex_mem_read_o,
             ex_mem_write_o, ex_mem_to_reg_o, illegal_o, stall_cnt_o,
             illegal_cnt_o
   );

   modport slave (
      input  instr_i, instr_valid_i, flush_i,
      output stall_o, ex_valid_o, ex_reg_write_o, ex_wreg_o, ex_rs_o, ex_rt_o,
             ex_alu_op_o, ex_alu_src_o, ex_reg_dst_o, ex_branch_o,
             ex_branch_ne_o, ex_jump_o, ex_link_o, ex_mem_read_o,
             ex_mem_write_o, ex_mem_to_reg_o, illegal_o, stall_cnt_o,
             illegal_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/id_ctrl_stage_main_dec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_main_dec                                                |
// | Description : Purely combinational opcode -> control word table.        |
// |   i_op   in   6        primary opcode instr[31:26]                        |
// |   o_ctrl out  ctrl_t   decoded control word (illegal flag for unknown)   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module id_main_dec
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] i_op,
   output ctrl_t      o_ctrl
);

   always_comb begin
      o_ctrl = CTRL_BUBBLE;
      case (i_op)
         OP_RTYPE: begin
            o_ctrl.regDst   = 1'b1;
            o_ctrl.regWrite = 1'b1;
            o_ctrl.rtUsed   = 1'b1;
            o_ctrl.aluOp    = ALUOP_FUNCT;
         end
         OP_LW: begin
            o_ctrl.aluSrc   = 1'b1;
            o_ctrl.memToReg = 1'b1;
            o_ctrl.regWrite = 1'b1;
            o_ctrl.memRead  = 1'b1;
            o_ctrl.aluOp    = ALUOP_ADD;
         end
         OP_SW: begin
            o_ctrl.aluSrc   = 1'b1;
            o_ctrl.memWrite = 1'b1;
            o_ctrl.rtUsed   = 1'b1;
            o_ctrl.aluOp    = ALUOP_ADD;
         end
         OP_BEQ, OP_BNE: begin
            o_ctrl.branch   = 1'b1;
            o_ctrl.branchNe = (i_op == OP_BNE);
            o_ctrl.rtUsed   = 1'b1;
            o_ctrl.aluOp    = ALUOP_SUB;
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
            o_ctrl.aluSrc   = 1'b1;
            o_ctrl.regWrite = 1'b1;
            case (i_op)
               OP_ADDI: o_ctrl.aluOp = ALUOP_ADDI;
               OP_SLTI: o_ctrl.aluOp = ALUOP_SLT;
               OP_ANDI: o_ctrl.aluOp = ALUOP_AND;
               OP_ORI:  o_ctrl.aluOp = ALUOP_OR;
               default: o_ctrl.aluOp = ALUOP_LUI;
            endcase
         end
         OP_J: begin
            o_ctrl.jump     = 1'b1;
         end
         OP_JAL: begin
            o_ctrl.jump     = 1'b1;
            o_ctrl.link     = 1'b1;
            o_ctrl.regWrite = 1'b1;
         end
         default: begin
            o_ctrl.illegal  = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/id_ctrl_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_ctrl_stage                                              |
// | Description : ID-stage main decoder for the 5-stage MIPS pipeline.       |
// |               Decodes the instruction, detects load-use hazards,         |
// |               honours flushes and registers the control fields into the  |
// |               ID/EX pipeline register. Counts stalls and illegal ops.    |
// |   clk_i  in  1   clock, rising edge                                      |
// |   rst_i  in  1   asynchronous active-high reset                          |
// |   bus    slave id_ctrl_stage_if: instruction in, stall and ID/EX out     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module id_ctrl_stage
   import mips_ctrl_pkg::*;
#(
   parameter int ALUOP_W     = 3,
   parameter int REG_AW      = 5,
   parameter int CNT_W       = 16,
   parameter int LOAD_USE_EN = 1
)(
   input  logic             clk_i,
   input  logic             rst_i,
   id_ctrl_stage_if.slave   bus
);

   localparam logic [REG_AW-1:0] c_LINK_REG = REG_AW'(31);
   localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};

   // ---------------- decode ----------------
   ctrl_t               w_dec;
   logic [REG_AW-1:0]   w_rs;
   logic [REG_AW-1:0]   w_rt;
   logic [REG_AW-1:0]   w_rd;
   logic [REG_AW-1:0]   w_wreg;
   logic                w_regWrite;
   logic [ALUOP_W-1:0]  w_aluOp;
   logic                w_unusedBits;

   id_main_dec u_mainDec (
      .i_op   (bus.instr_i[31:26]),
      .o_ctrl (w_dec)
   );

   assign w_rs = REG_AW'(bus.instr_i[25:21]);
   assign w_rt = REG_AW'(bus.instr_i[20:16]);
   assign w_rd = REG_AW'(bus.instr_i[15:11]);

   // shamt/funct are consumed by the EX-stage ALU controller, not here
   assign w_unusedBits = ^bus.instr_i[10:0];

   assign w_wreg     = w_dec.regDst ? w_rd : (w_dec.link ? c_LINK_REG : w_rt);
   // Writes to $0 are architecturally discarded; drop them here so that
   // forwarding and hazard logic never see $0 as a producer.
   assign w_regWrite = w_dec.regWrite & (w_wreg != '0);

   if (ALUOP_W > 3) begin : g_aluOpPad
      assign w_aluOp = {{(ALUOP_W-3){1'b0}}, w_dec.aluOp};
   end else begin : g_aluOpExact
      assign w_aluOp = w_dec.aluOp;
   end

   // ---------------- ID/EX register state ----------------
   logic                r_exValid;
   logic                r_regWrite;
   logic [REG_AW-1:0]   r_wreg;
   logic [REG_AW-1:0]   r_rs;
   logic [REG_AW-1:0]   r_rt;
   logic [ALUOP_W-1:0]  r_aluOp;
   logic                r_aluSrc;
   logic                r_regDst;
   logic                r_branch;
   logic                r_branchNe;
   logic                r_jump;
   logic                r_link;
   logic                r_memRead;
   logic                r_memWrite;
   logic                r_memToReg;
   logic                r_illegal;
   logic [CNT_W-1:0]    r_stallCnt;
   logic [CNT_W-1:0]    r_illegalCnt;

   // ---------------- hazard ----------------
   logic w_srcMatch;
   logic w_hazard;
   logic w_stall;
   logic w_load;      // ID instruction leaves ID this edge
   logic w_accept;    // ...and is a legal instruction entering EX

   // rs is compared unconditionally; rt only when the opcode reads it
   assign w_srcMatch = (r_wreg == w_rs) || (w_dec.rtUsed && (r_wreg == w_rt));
   assign w_hazard   = (LOAD_USE_EN != 0) && r_exValid && r_memRead &&
                       (r_wreg != '0) && bus.instr_valid_i && w_srcMatch;
   // A flush discards the dependent instruction, so stalling would be wasted
   assign w_stall    = w_hazard & ~bus.flush_i;
   assign w_load     = bus.instr_valid_i & ~bus.flush_i & ~w_stall;
   assign w_accept   = w_load & ~w_dec.illegal;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_exValid  <= 1'b0;
         r_regWrite <= 1'b0;
         r_wreg     <= '0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_aluOp    <= '0;
         r_aluSrc   <= 1'b0;
         r_regDst   <= 1'b0;
         r_branch   <= 1'b0;
         r_branchNe <= 1'b0;
         r_jump     <= 1'b0;
         r_link     <= 1'b0;
         r_memRead  <= 1'b0;
         r_memWrite <= 1'b0;
         r_memToReg <= 1'b0;
         r_illegal  <= 1'b0;
      end else if (w_accept) begin
         r_exValid  <= 1'b1;
         r_regWrite <= w_regWrite;
         r_wreg     <= w_wreg;
         r_rs       <= w_rs;
         r_rt       <= w_rt;
         r_aluOp    <= w_aluOp;
         r_aluSrc   <= w_dec.aluSrc;
         r_regDst   <= w_dec.regDst;
         r_branch   <= w_dec.branch;
         r_branchNe <= w_dec.branchNe;
         r_jump     <= w_dec.jump;
         r_link     <= w_dec.link;
         r_memRead  <= w_dec.memRead;
         r_memWrite <= w_dec.memWrite;
         r_memToReg <= w_dec.memToReg;
         r_illegal  <= 1'b0;
      end else begin
         // Bubble. An illegal opcode also travels as a bubble, flagged only
         // by the illegal pulse so nothing downstream acts on it.
         r_exValid  <= 1'b0;
         r_regWrite <= 1'b0;
         r_wreg     <= '0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_aluOp    <= '0;
         r_aluSrc   <= 1'b0;
         r_regDst   <= 1'b0;
         r_branch   <= 1'b0;
         r_branchNe <= 1'b0;
         r_jump     <= 1'b0;
         r_link     <= 1'b0;
         r_memRead  <= 1'b0;
         r_memWrite <= 1'b0;
         r_memToReg <= 1'b0;
         r_illegal  <= w_load & w_dec.illegal;
      end
   end

   // ---------------- saturating counters ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stallCnt   <= '0;
         r_illegalCnt <= '0;
      end else begin
         if (w_stall && (r_stallCnt != c_CNT_MAX)) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
         end
         if (w_load && w_dec.illegal && (r_illegalCnt != c_CNT_MAX)) begin
            r_illegalCnt <= r_illegalCnt + CNT_W'(1);
         end
      end
   end

   // ---------------- outputs ----------------
   assign bus.stall_o         = w_stall;
   assign bus.ex_valid_o      = r_exValid;
   assign bus.ex_reg_write_o  = r_regWrite;
   assign bus.ex_wreg_o       = r_wreg;
   assign bus.ex_rs_o         = r_rs;
   assign bus.ex_rt_o         = r_rt;
   assign bus.ex_alu_op_o     = r_aluOp;
   assign bus.ex_alu_src_o    = r_aluSrc;
   assign bus.ex_reg_dst_o    = r_regDst;
   assign bus.ex_branch_o     = r_branch;
   assign bus.ex_branch_ne_o  = r_branchNe;
   assign bus.ex_jump_o       = r_jump;
   assign bus.ex_link_o       = r_link;
   assign bus.ex_mem_read_o   = r_memRead;
   assign bus.ex_mem_write_o  = r_memWrite;
   assign bus.ex_mem_to_reg_o = r_memToReg;
   assign bus.illegal_o       = r_illegal;
   assign bus.stall_cnt_o     = r_stallCnt;
   assign bus.illegal_cnt_o   = r_illegalCnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ctrl_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_id_ctrl_stage                                           |
// | Description : Self-checking bench for id_ctrl_stage. A 16-bit-counter    |
// |               instance and a 2-bit-counter instance share one stimulus   |
// |               stream; expected ID/EX contents are queued per cycle.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_id_ctrl_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] tbInstr;
   logic        tbValid;
   logic        tbFlush;

   always #5 clk = ~clk;

   id_ctrl_stage_if #(.ALUOP_W(3), .REG_AW(5), .CNT_W(16)) bus ();
   id_ctrl_stage_if #(.ALUOP_W(3), .REG_AW(5), .CNT_W(2))  bus2 ();

   assign bus.instr_i        = tbInstr;
   assign bus.instr_valid_i  = tbValid;
   assign bus.flush_i        = tbFlush;
   assign bus2.instr_i       = tbInstr;
   assign bus2.instr_valid_i = tbValid;
   assign bus2.flush_i       = tbFlush;

   id_ctrl_stage #(.ALUOP_W(3), .REG_AW(5), .CNT_W(16), .LOAD_USE_EN(1)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   id_ctrl_stage #(.ALUOP_W(3), .REG_AW(5), .CNT_W(2), .LOAD_USE_EN(1)) dut2 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus2.slave)
   );

   typedef struct packed {
      logic       valid;
      logic       regWrite;
      logic [4:0] wreg;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [2:0] aluOp;
      logic       aluSrc;
      logic       regDst;
      logic       branch;
      logic       branchNe;
      logic       jump;
      logic       link;
      logic       memRead;
      logic       memWrite;
      logic       memToReg;
      logic       illegal;
   } exState_t;

   int       checks   = 0;
   int       failures = 0;
   exState_t sb[$];
   logic     obsStall;
   logic     obsStall2;
   int       mStall, mStall2, mIll, mIll2;

   // ---------------- encoders ----------------
   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] jtype(input int op, input int tgt);
      return {6'(op), 26'(tgt)};
   endfunction

   // ---------------- reference decode ----------------
   function automatic exState_t modelDecode(input logic [31:0] ins);
      exState_t e;
      e       = '0;
      e.valid = 1'b1;
      e.rs    = ins[25:21];
      e.rt    = ins[20:16];
      case (ins[31:26])
         6'h00: begin e.regDst = 1; e.regWrite = 1; e.aluOp = 3'b010; end
         6'h23: begin e.aluSrc = 1; e.memToReg = 1; e.regWrite = 1; e.memRead = 1; end
         6'h2B: begin e.aluSrc = 1; e.memWrite = 1; end
         6'h04: begin e.branch = 1; e.aluOp = 3'b001; end
         6'h05: begin e.branch = 1; e.branchNe = 1; e.aluOp = 3'b001; end
         6'h08: begin e.aluSrc = 1; e.regWrite = 1; e.aluOp = 3'b011; end
         6'h0A: begin e.aluSrc = 1; e.regWrite = 1; e.aluOp = 3'b100; end
         6'h0C: begin e.aluSrc = 1; e.regWrite = 1; e.aluOp = 3'b101; end
         6'h0D: begin e.aluSrc = 1; e.regWrite = 1; e.aluOp = 3'b110; end
         6'h0F: begin e.aluSrc = 1; e.regWrite = 1; e.aluOp = 3'b111; end
         6'h02: begin e.jump = 1; end
         6'h03: begin e.jump = 1; e.link = 1; e.regWrite = 1; end
         default: begin
            e         = '0;
            e.illegal = 1'b1;
            return e;
         end
      endcase
      if (e.regDst)    e.wreg = ins[15:11];
      else if (e.link) e.wreg = 5'd31;
      else             e.wreg = ins[20:16];
      if (e.wreg == 5'd0) e.regWrite = 1'b0;
      return e;
   endfunction

   function automatic exState_t observe();
      exState_t o;
      o.valid    = bus.ex_valid_o;
      o.regWrite = bus.ex_reg_write_o;
      o.wreg     = bus.ex_wreg_o;
      o.rs       = bus.ex_rs_o;
      o.rt       = bus.ex_rt_o;
      o.aluOp    = bus.ex_alu_op_o;
      o.aluSrc   = bus.ex_alu_src_o;
      o.regDst   = bus.ex_reg_dst_o;
      o.branch   = bus.ex_branch_o;
      o.branchNe = bus.ex_branch_ne_o;
      o.jump     = bus.ex_jump_o;
      o.link     = bus.ex_link_o;
      o.memRead  = bus.ex_mem_read_o;
      o.memWrite = bus.ex_mem_write_o;
      o.memToReg = bus.ex_mem_to_reg_o;
      o.illegal  = bus.illegal_o;
      return o;
   endfunction

   // Drives one ID cycle, records the combinational stall, queues the
   // ID/EX contents expected after the edge and advances the model counters.
   task automatic tick(input logic [31:0] ins, input logic v, input logic fl, input logic expSt);
      exState_t e;
      @(negedge clk);
      tbInstr = ins;
      tbValid = v;
      tbFlush = fl;
      #1;
      obsStall  = bus.stall_o;
      obsStall2 = bus2.stall_o;
      if (fl || expSt || !v) e = '0;
      else                   e = modelDecode(ins);
      sb.push_back(e);
      if (expSt) begin
         mStall++;
         if (mStall2 < 3) mStall2++;
      end
      if (!fl && !expSt && v && modelDecode(ins).illegal) begin
         mIll++;
         if (mIll2 < 3) mIll2++;
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      tbInstr = itype(8'h23, 1, 8, 0);
      tbValid = 1'b1;
      tbFlush = 1'b0;
      #1;
      checks++;
      if (observe() !== exState_t'(0)) begin
         failures++;
         $display("FAIL reset_ex got=%h exp=0", observe());
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (observe() !== exState_t'(0) || bus.stall_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_held got=%h stall=%b exp=0", observe(), bus.stall_o);
      end
      checks++;
      if (bus.stall_cnt_o !== 16'd0 || bus.illegal_cnt_o !== 16'd0) begin
         failures++;
         $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.stall_cnt_o, bus.illegal_cnt_o);
      end
      @(negedge clk);
      tbValid = 1'b0;
      rst     = 1'b0;
   endtask

   task automatic test_load_use();
      logic [31:0] seq [6];
      logic        stl [6];
      exState_t    exp;
      seq[0] = itype(8'h23, 1, 8, 0);  stl[0] = 0;   // lw  $8,0($1)
      seq[1] = rtype(8, 2, 9);         stl[1] = 1;   // add $9,$8,$2
      seq[2] = rtype(8, 2, 9);         stl[2] = 0;
      seq[3] = itype(8'h23, 1, 8, 0);  stl[3] = 0;
      seq[4] = itype(8'h23, 8, 9, 0);  stl[4] = 1;   // lw  $9,0($8)
      seq[5] = itype(8'h23, 8, 9, 0);  stl[5] = 0;
      for (int i = 0; i < 6; i++) begin
         tick(seq[i], 1'b1, 1'b0, stl[i]);
         checks++;
         if ({obsStall, obsStall2} !== {stl[i], stl[i]}) begin
            failures++;
            $display("FAIL load_use_stall[%0d] got=%b%b exp=%b", i, obsStall, obsStall2, stl[i]);
         end
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL load_use_sb[%0d] got=empty exp=entry", i);
         end else begin
            exp = sb.pop_front();
            if (observe() !== exp) begin
               failures++;
               $display("FAIL load_use_ex[%0d] got=%h exp=%h", i, observe(), exp);
            end
         end
         if (i == 2) begin
            checks++;
            if (bus.stall_cnt_o !== 16'd1) begin
               failures++;
               $display("FAIL load_use_cnt got=%0d exp=1", bus.stall_cnt_o);
            end
         end
      end
   endtask

   task automatic test_store_dep();
      logic [31:0] seq [13];
      logic        vld [13];
      logic        stl [13];
      exState_t    exp;
      seq[0]  = 32'h0;                  vld[0]  = 0; stl[0]  = 0;
      seq[1]  = itype(8'h23, 1, 8, 0);  vld[1]  = 1; stl[1]  = 0;  // lw $8
      seq[2]  = itype(8'h2B, 3, 8, 4);  vld[2]  = 1; stl[2]  = 1;  // sw $8,4($3)
      seq[3]  = itype(8'h2B, 3, 8, 4);  vld[3]  = 1; stl[3]  = 0;
      seq[4]  = itype(8'h23, 1, 8, 0);  vld[4]  = 1; stl[4]  = 0;
      seq[5]  = itype(8'h08, 8, 9, 1);  vld[5]  = 1; stl[5]  = 1;  // addi $9,$8,1
      seq[6]  = itype(8'h08, 8, 9, 1);  vld[6]  = 1; stl[6]  = 0;
      seq[7]  = itype(8'h23, 1, 0, 0);  vld[7]  = 1; stl[7]  = 0;  // lw $0
      seq[8]  = rtype(0, 2, 9);         vld[8]  = 1; stl[8]  = 0;  // add $9,$0,$2
      seq[9]  = itype(8'h23, 1, 8, 0);  vld[9]  = 1; stl[9]  = 0;
      seq[10] = rtype(8, 2, 9);         vld[10] = 0; stl[10] = 0;  // not valid
      seq[11] = itype(8'h23, 1, 8, 0);  vld[11] = 1; stl[11] = 0;
      seq[12] = itype(8'h08, 1, 8, 1);  vld[12] = 1; stl[12] = 0;  // rt not a source
      for (int i = 0; i < 13; i++) begin
         tick(seq[i], vld[i], 1'b0, stl[i]);
         checks++;
         if ({obsStall, obsStall2} !== {stl[i], stl[i]}) begin
            failures++;
            $display("FAIL store_dep_stall[%0d] got=%b%b exp=%b", i, obsStall, obsStall2, stl[i]);
         end
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL store_dep_sb[%0d] got=empty exp=entry", i);
         end else begin
            exp = sb.pop_front();
            if (observe() !== exp) begin
               failures++;
               $display("FAIL store_dep_ex[%0d] got=%h exp=%h", i, observe(), exp);
            end
         end
      end
      checks++;
      if (bus.stall_cnt_o !== 16'(mStall) || bus2.stall_cnt_o !== 2'(mStall2)) begin
         failures++;
         $display("FAIL store_dep_cnt got=%0d/%0d exp=%0d/%0d", bus.stall_cnt_o, bus2.stall_cnt_o, mStall, mStall2);
      end
   endtask

   task automatic test_flush_hazard();
      logic [31:0] seq [4];
      logic        fls [4];
      exState_t    exp;
      int          cntBefore;
      cntBefore = mStall;
      seq[0] = itype(8'h23, 1, 8, 0);      fls[0] = 0;
      seq[1] = rtype(8, 2, 9);             fls[1] = 1;   // hazard + flush
      seq[2] = rtype(8, 2, 9);             fls[2] = 0;
      seq[3] = itype(8'h0D, 1, 4, 8'hFF);  fls[3] = 1;   // plain flush
      for (int i = 0; i < 4; i++) begin
         tick(seq[i], 1'b1, fls[i], 1'b0);
         checks++;
         if (obsStall !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall[%0d] got=%b exp=0", i, obsStall);
         end
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL flush_sb[%0d] got=empty exp=entry", i);
         end else begin
            exp = sb.pop_front();
            if (observe() !== exp) begin
               failures++;
               $display("FAIL flush_ex[%0d] got=%h exp=%h", i, observe(), exp);
            end
         end
      end
      checks++;
      if (bus.stall_cnt_o !== 16'(cntBefore)) begin
         failures++;
         $display("FAIL flush_cnt got=%0d exp=%0d", bus.stall_cnt_o, cntBefore);
      end
   endtask

   task automatic test_decode();
      logic [31:0] seq [13];
      exState_t    exp;
      seq[0]  = rtype(1, 2, 3);
      seq[1]  = itype(8'h23, 4, 5, 8);
      seq[2]  = itype(8'h2B, 7, 6, 0);
      seq[3]  = itype(8'h04, 1, 2, 3);
      seq[4]  = itype(8'h05, 1, 2, 16'hFFFD);
      seq[5]  = itype(8'h08, 1, 10, 5);
      seq[6]  = itype(8'h0A, 1, 11, 7);
      seq[7]  = itype(8'h0C, 2, 12, 255);
      seq[8]  = itype(8'h0D, 3, 13, 16'h1234);
      seq[9]  = itype(8'h0F, 0, 14, 16'hABCD);
      seq[10] = jtype(8'h02, 26'h100);
      seq[11] = jtype(8'h03, 26'h3E0200);
      seq[12] = itype(8'h08, 1, 0, 5);             // addi $0,$1,5
      for (int i = 0; i < 13; i++) begin
         tick(seq[i], 1'b1, 1'b0, 1'b0);
         checks++;
         if (obsStall !== 1'b0) begin
            failures++;
            $display("FAIL decode_stall[%0d] got=%b exp=0", i, obsStall);
         end
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL decode_sb[%0d] got=empty exp=entry", i);
         end else begin
            exp = sb.pop_front();
            if (observe() !== exp) begin
               failures++;
               $display("FAIL decode_ex[%0d] got=%h exp=%h", i, observe(), exp);
            end
         end
         if (i == 11) begin
            checks++;
            if (bus.ex_wreg_o !== 5'd31 || bus.ex_reg_write_o !== 1'b1) begin
               failures++;
               $display("FAIL decode_jal got=wreg%0d rw%b exp=wreg31 rw1", bus.ex_wreg_o, bus.ex_reg_write_o);
            end
         end
         if (i == 12) begin
            checks++;
            if (bus.ex_reg_write_o !== 1'b0 || bus.ex_valid_o !== 1'b1) begin
               failures++;
               $display("FAIL decode_r0 got=rw%b v%b exp=rw0 v1", bus.ex_reg_write_o, bus.ex_valid_o);
            end
         end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] seq [8];
      exState_t    exp;
      seq[0] = itype(8'h3F, 1, 2, 3);
      seq[1] = rtype(1, 2, 3);
      seq[2] = itype(8'h3F, 0, 0, 0);
      seq[3] = itype(8'h01, 1, 0, 4);
      seq[4] = itype(8'h3E, 2, 2, 2);
      seq[5] = itype(8'h10, 0, 4, 0);
      seq[6] = itype(8'h2F, 5, 6, 7);
      seq[7] = rtype(4, 5, 6);
      for (int i = 0; i < 8; i++) begin
         tick(seq[i], 1'b1, 1'b0, 1'b0);
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL illegal_sb[%0d] got=empty exp=entry", i);
         end else begin
            exp = sb.pop_front();
            if (observe() !== exp || bus2.illegal_o !== exp.illegal) begin
               failures++;
               $display("FAIL illegal_ex[%0d] got=%h exp=%h", i, observe(), exp);
            end
         end
         if (i == 1) begin
            checks++;
            if (bus.illegal_cnt_o !== 16'd1 || bus2.illegal_cnt_o !== 2'd1) begin
               failures++;
               $display("FAIL illegal_cnt1 got=%0d/%0d exp=1/1", bus.illegal_cnt_o, bus2.illegal_cnt_o);
            end
         end
      end
      checks++;
      if (bus.illegal_cnt_o !== 16'(mIll) || bus2.illegal_cnt_o !== 2'd3) begin
         failures++;
         $display("FAIL illegal_sat got=%0d/%0d exp=%0d/3", bus.illegal_cnt_o, bus2.illegal_cnt_o, mIll);
      end
   endtask

   task automatic test_reset_midstream();
      exState_t exp;
      tick(itype(8'h23, 1, 8, 0), 1'b1, 1'b0, 1'b0);
      checks++;
      exp = sb.pop_front();
      if (observe() !== exp) begin
         failures++;
         $display("FAIL midrst_pre got=%h exp=%h", observe(), exp);
      end
      @(negedge clk);
      tbInstr = itype(8'h23, 1, 9, 0);
      tbValid = 1'b1;
      tbFlush = 1'b0;
      #2 rst  = 1'b1;
      #1;
      checks++;
      if (observe() !== exState_t'(0) || bus.stall_o !== 1'b0) begin
         failures++;
         $display("FAIL midrst_ex got=%h stall=%b exp=0", observe(), bus.stall_o);
      end
      checks++;
      if (bus.stall_cnt_o !== 16'd0 || bus.illegal_cnt_o !== 16'd0 ||
          bus2.stall_cnt_o !== 2'd0 || bus2.illegal_cnt_o !== 2'd0) begin
         failures++;
         $display("FAIL midrst_cnt got=%0d/%0d/%0d/%0d exp=0", bus.stall_cnt_o,
                  bus.illegal_cnt_o, bus2.stall_cnt_o, bus2.illegal_cnt_o);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      mStall = 0; mStall2 = 0; mIll = 0; mIll2 = 0;
      tick(itype(8'h23, 1, 9, 0), 1'b1, 1'b0, 1'b0);
      checks++;
      exp = sb.pop_front();
      if (observe() !== exp) begin
         failures++;
         $display("FAIL midrst_post got=%h exp=%h", observe(), exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mStall = 0; mStall2 = 0; mIll = 0; mIll2 = 0;
      tbInstr = '0;
      tbValid = 1'b0;
      tbFlush = 1'b0;
      test_reset();
      test_load_use();
      test_store_dep();
      test_flush_hazard();
      test_decode();
      test_illegal();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
